gppcu_issue_ctrl: RTL
=====================

// Module: gppcu_issue_ctrl
// PURPOSE
//   Parametrised instruction-issue front end for the GPPCU SIMT core. Buffers incoming
//   instructions in an IQ_DEPTH-entry queue and tracks pending register writes in a
//   NUMREG-bit scoreboard. Issues one instruction per cycle to all threads when the
//   instruction has no RAW/WAW hazard and the execute stage is not busy.
//   Sits between the instruction source and the decode/exec/writeback pipeline.
// PARAMETERS
//   DBW       32  instruction width
//   NUMREG    32  architectural registers per thread (power of 2)
//   RBW       5   register index width, log2(NUMREG)
//   IQ_DEPTH  4   instruction queue entries (power of 2, >=2)
//   FLD_D     22  LSB of REGD field in instruction
//   FLD_A     17  LSB of REGA field
//   FLD_B     0   LSB of REGB field
//   SCW       16  stall counter width
// PORTS
//   iACLK          in   1       clock, rising edge
//   inRST          in   1       async active-low reset
//   iINSTR         in   DBW     instruction in
//   iINSTR_VALID   in   1       iINSTR valid
//   oINSTR_READY   out  1       queue can accept; transfer on VALID&READY at edge
//   iFLUSH         in   1       sync flush: discard all queued instructions
//   oHEAD_INSTR    out  DBW     queue head, combinational, goes to external decoder
//   iHEAD_USEA     in   1       head reads REGA (from decoder, combinational)
//   iHEAD_USEB     in   1       head reads REGB
//   iHEAD_REGWR    in   1       head writes REGD
//   iEXEC_BUSY     in   1       thread 0 multi-cycle unit busy; blocks issue
//   iWB_VALID      in   1       writeback retiring a register write this cycle
//   iWB_REG        in   RBW     register being written back
//   oISSUE_VALID   out  1       one-cycle pulse: oISSUE_INSTR valid
//   oISSUE_INSTR   out  DBW     issued instruction, registered
//   oPENDING       out  NUMREG  scoreboard bit vector, registered
//   oIQ_COUNT      out  log2(IQ_DEPTH)+1  queue occupancy
//   oSTALL_CNT     out  SCW     saturating count of hazard/busy stall cycles
// BEHAVIOUR
//   Reset (inRST=0, async, any time): queue empty, oINSTR_READY=1 after release,
//     oISSUE_VALID=0, oISSUE_INSTR=0, oPENDING=0, oIQ_COUNT=0, oSTALL_CNT=0.
//   Queue: oINSTR_READY = (count != IQ_DEPTH); push on VALID&READY; ptrs wrap mod IQ_DEPTH.
//     Simultaneous push+pop when full is not allowed (READY=0); when empty, push then pop
//     next cycle (no bypass from iINSTR to issue).
//   Hazard (head, count!=0): (USEA & P[REGA]) | (USEB & P[REGB]) | (REGWR & P[REGD]).
//     P = oPENDING (registered value); see WB bypass under CONFIGURATION.
//   Issue condition: count!=0 & ~hazard & ~iEXEC_BUSY & ~iFLUSH. On issue at edge k:
//     pop head, oISSUE_INSTR<=head, oISSUE_VALID=1 for the cycle after k, else 0.
//   Latency: instruction accepted at edge k issues earliest at edge k+1.
//   Scoreboard: next P = (P & ~clr) | set; set = onehot(REGD) if issuing & REGWR;
//     clr = onehot(iWB_REG) if iWB_VALID. Set wins over clear on same register.
//     iWB_VALID for a non-pending register: no effect.
//   Stall counter: +1 each cycle count!=0 & ~issue & ~iFLUSH; saturates at 2^SCW-1.
//   Flush: at edge with iFLUSH=1, count<=0, ptrs reset, no issue, push that cycle
//     discarded; scoreboard and outstanding writebacks unaffected.
//   iEXEC_BUSY held: queue keeps filling until full; no issue, stall counter counts.
// CONFIGURATION
//   GPPCU_ISSUE_WB_BYPASS_EN defined: hazard uses P & ~clr (same-cycle writeback clears
//     hazard; dependent instruction issues on the writeback edge).
//   Not defined: hazard uses registered P; dependent issues one edge after writeback.
// TESTING
//   1 Four independent instrs (no REGWR overlap, BUSY=0) pushed back-to-back -> oISSUE_VALID
//     high 4 consecutive cycles, first one edge after first push, order preserved.
//   2 I0 writes r2, I1 reads r2; iWB_VALID,iWB_REG=2 at edge t -> I1 issues at t+1
//     (bypass off) / at t (GPPCU_ISSUE_WB_BYPASS_EN); oPENDING[2] 1 then 0.
//   3 iEXEC_BUSY=1, push 5 instrs (IQ_DEPTH=4) -> READY=0 after 4th, oIQ_COUNT=4, 5th held;
//     BUSY=0 -> 4 issues, 5th accepted, oSTALL_CNT = busy cycles with count!=0.
//   4 Queue holds 3, r5 pending; assert iFLUSH one cycle -> oIQ_COUNT=0, READY=1,
//     oPENDING[5] still 1, no oISSUE_VALID pulse.
//   5 Drop inRST mid-stream with 2 queued, r1,r3 pending -> outputs zero immediately
//     (async), no issue after release until new push.
//   6 SCW=4, hold hazard 20 cycles -> oSTALL_CNT stops at 15.

Source files
------------

// File: rtl/gppcu_issue_ctrl.sv
// gppcu_issue_ctrl: instruction queue plus scoreboard issue front end; define GPPCU_ISSUE_WB_BYPASS_EN so a same-cycle writeback clears a hazard
module gppcu_issue_ctrl #(
  parameter int DBW      = 32,
  parameter int NUMREG   = 32,
  parameter int RBW      = 5,
  parameter int IQ_DEPTH = 4,
  parameter int FLD_D    = 22,
  parameter int FLD_A    = 17,
  parameter int FLD_B    = 0,
  parameter int SCW      = 16
) (
  input  logic                        iACLK,
  input  logic                        inRST,
  input  logic [DBW-1:0]              iINSTR,
  input  logic                        iINSTR_VALID,
  output logic                        oINSTR_READY,
  input  logic                        iFLUSH,
  output logic [DBW-1:0]              oHEAD_INSTR,
  input  logic                        iHEAD_USEA,
  input  logic                        iHEAD_USEB,
  input  logic                        iHEAD_REGWR,
  input  logic                        iEXEC_BUSY,
  input  logic                        iWB_VALID,
  input  logic [RBW-1:0]              iWB_REG,
  output logic                        oISSUE_VALID,
  output logic [DBW-1:0]              oISSUE_INSTR,
  output logic [NUMREG-1:0]           oPENDING,
  output logic [$clog2(IQ_DEPTH):0]   oIQ_COUNT,
  output logic [SCW-1:0]              oSTALL_CNT
);
  localparam int IQW = $clog2(IQ_DEPTH);
  logic [DBW-1:0]    iqMem [IQ_DEPTH];
  logic [IQW-1:0]    wrPtr, rdPtr;
  logic              notEmpty, push, issue, hazard, stallInc;
  logic [RBW-1:0]    regD, regA, regB;
  logic [NUMREG-1:0] clrMask, setMask, hzPend;
  assign oINSTR_READY = oIQ_COUNT != (IQW+1)'(IQ_DEPTH);
  assign notEmpty     = oIQ_COUNT != '0;
  assign push         = iINSTR_VALID & oINSTR_READY & ~iFLUSH;
  assign oHEAD_INSTR  = iqMem[rdPtr];
  assign regD         = oHEAD_INSTR[FLD_D +: RBW];
  assign regA         = oHEAD_INSTR[FLD_A +: RBW];
  assign regB         = oHEAD_INSTR[FLD_B +: RBW];
  // Hazard check against the scoreboard, optionally letting this cycle's writeback through
  always_comb begin
    clrMask  = iWB_VALID ? NUMREG'(1) << iWB_REG : '0;
`ifdef GPPCU_ISSUE_WB_BYPASS_EN
    hzPend   = oPENDING & ~clrMask;
`else
    hzPend   = oPENDING;
`endif
    hazard   = (iHEAD_USEA & hzPend[regA]) | (iHEAD_USEB & hzPend[regB]) | (iHEAD_REGWR & hzPend[regD]);
    issue    = notEmpty & ~hazard & ~iEXEC_BUSY & ~iFLUSH;
    setMask  = (issue & iHEAD_REGWR) ? NUMREG'(1) << regD : '0;
    stallInc = notEmpty & ~issue & ~iFLUSH & ~&oSTALL_CNT;
  end
  // Queue storage needs no reset; occupancy decides which entries are live
  always_ff @(posedge iACLK)
    if (push) iqMem[wrPtr] <= iINSTR;
  // Pointers, occupancy, issue register, scoreboard and stall counter
  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      oIQ_COUNT    <= '0;
      oISSUE_VALID <= 1'b0;
      oISSUE_INSTR <= '0;
      oPENDING     <= '0;
      oSTALL_CNT   <= '0;
    end else begin
      wrPtr        <= iFLUSH ? '0 : wrPtr + IQW'(push);
      rdPtr        <= iFLUSH ? '0 : rdPtr + IQW'(issue);
      oIQ_COUNT    <= iFLUSH ? '0 : oIQ_COUNT + (IQW+1)'(push) - (IQW+1)'(issue);
      oISSUE_VALID <= issue;
      oISSUE_INSTR <= issue ? oHEAD_INSTR : oISSUE_INSTR;
      oPENDING     <= (oPENDING & ~clrMask) | setMask;
      oSTALL_CNT   <= oSTALL_CNT + SCW'(stallInc);
    end
  end
endmodule
